uart_reg_ctrl: RTL and testbench

// Parametrised byte-command register controller between uart_ss and the audio datapath. Decodes
// the serial command stream into a register file: bit7=1 write (cmd, data), bit7=0 read (cmd -> reply).

---
 rtl/uart_reg_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_ctrl.sv
// Byte-command register controller sitting between uart_ss and the audio datapath.
// Serial protocol: a command byte with bit7=1 is a write (cmd, data); bit7=0 is a read
// (cmd -> one reply byte). It drives per-voice note strobes, a programmable sample tick
// and the LED register. It also reports status for write timeouts and bad addresses/voices.
// Ports:
//   clk96m         system clock
//   rst            synchronous reset, active high
//   data_rx        received byte, qualified by valid_data_rx (1-cycle strobe)
//   data_tx        reply byte, qualified by valid_data_tx (1-cycle strobe)
//   note_on/off    1-cycle strobe per voice
//   active         level per voice, set by NOTE_ON and cleared by NOTE_OFF
//   sample_tick    1-cycle strobe every RATE_DIV+1 cycles
//   led            LED register
module uart_reg_ctrl #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 960000,
  parameter logic [15:0] RATE_DIV_RST   = 16'd2000,
  parameter logic [7:0]  ID_VALUE       = 8'h5A
) (
  input  logic                  clk96m,
  input  logic                  rst,
  input  logic [7:0]            data_rx,
  input  logic                  valid_data_rx,
  output logic [7:0]            data_tx,
  output logic                  valid_data_tx,
  output logic [NUM_VOICES-1:0] note_on,
  output logic [NUM_VOICES-1:0] note_off,
  output logic [NUM_VOICES-1:0] active,
  output logic                  sample_tick,
  output logic [3:0]            led
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] A_ID       = 7'h00;
  localparam logic [6:0] A_STATUS   = 7'h01;
  localparam logic [6:0] A_DIV_LO   = 7'h02;
  localparam logic [6:0] A_DIV_HI   = 7'h03;
  localparam logic [6:0] A_LED      = 7'h04;
  localparam logic [6:0] A_NOTE_ON  = 7'h05;
  localparam logic [6:0] A_NOTE_OFF = 7'h06;
  localparam logic [6:0] A_ACTIVE   = 7'h07;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_RESP = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic [6:0]            addr_q,     addr_d;
  logic [TO_W-1:0]       to_cnt_q,   to_cnt_d;
  logic [15:0]           div_q,      div_d;
  logic [7:0]            div_sh_q,   div_sh_d;
  logic [15:0]           tick_cnt_q, tick_cnt_d;
  logic                  tick_q,     tick_d;
  logic                  bad_q,      bad_d;
  logic                  tmo_q,      tmo_d;
  logic [3:0]            led_q,      led_d;
  logic [NUM_VOICES-1:0] active_q,   active_d;
  logic [NUM_VOICES-1:0] note_on_q,  note_on_d;
  logic [NUM_VOICES-1:0] note_off_q, note_off_d;
  logic [7:0]            data_tx_q,  data_tx_d;
  logic                  vtx_q,      vtx_d;

  logic [7:0]            rd_data_c;
  logic                  rd_bad_c;
  logic [NUM_VOICES-1:0] voice_sel_c;
  logic                  voice_ok_c;
  logic                  set_bad, set_tmo, clr_status;

  // Read mux, indexed by the incoming command byte so the reply can be registered on the command edge
  always_comb begin
    rd_data_c = 8'h00;
    rd_bad_c  = 1'b0;
    case (data_rx[6:0])
      A_ID:       rd_data_c = ID_VALUE;
      A_STATUS:   rd_data_c = {6'b0, bad_q, tmo_q};
      A_DIV_LO:   rd_data_c = div_q[7:0];
      A_DIV_HI:   rd_data_c = div_q[15:8];
      A_LED:      rd_data_c = {4'b0, led_q};
      A_NOTE_ON,
      A_NOTE_OFF: rd_data_c = 8'h00;
      A_ACTIVE:   rd_data_c = 8'(active_q);
      default: begin
        rd_data_c = 8'h00;
        rd_bad_c  = 1'b1;
      end
    endcase
  end

  // One-hot voice select from the data byte; out-of-range indices select nothing
  always_comb begin
    voice_ok_c = (data_rx < 8'(NUM_VOICES));
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_sel_c[v] = (data_rx == 8'(v));
    end
  end

  // Next-state, register file and output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    to_cnt_d   = to_cnt_q;
    div_d      = div_q;
    div_sh_d   = div_sh_q;
    led_d      = led_q;
    active_d   = active_q;
    note_on_d  = '0;
    note_off_d = '0;
    data_tx_d  = data_tx_q;
    vtx_d      = 1'b0;
    set_bad    = 1'b0;
    set_tmo    = 1'b0;
    clr_status = 1'b0;
    bad_d      = bad_q;
    tmo_d      = tmo_q;

    // Free-running sample divider, 0..DIV
    if (tick_cnt_q == div_q) begin
      tick_cnt_d = 16'd0;
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 16'd1;
      tick_d     = 1'b0;
    end

    case (state_q)
      IDLE, RD_RESP: begin
        state_d = IDLE;
        if (valid_data_rx) begin
          addr_d = data_rx[6:0];
          if (data_rx[7]) begin
            state_d  = WR_DATA;
            to_cnt_d = '0;
          end else begin
            state_d    = RD_RESP;
            data_tx_d  = rd_data_c;
            vtx_d      = 1'b1;
            clr_status = (data_rx[6:0] == A_STATUS);
            set_bad    = rd_bad_c;
          end
        end
      end
      WR_DATA: begin
        if (valid_data_rx) begin
          state_d = IDLE;
          case (addr_q)
            A_DIV_LO: div_sh_d = data_rx;
            A_DIV_HI: begin
              // Atomic commit; the divider restarts cleanly from 0
              div_d      = {data_rx, div_sh_q};
              tick_cnt_d = 16'd0;
              tick_d     = 1'b0;
            end
            A_LED: led_d = data_rx[3:0];
            A_NOTE_ON: begin
              if (voice_ok_c) begin
                note_on_d = voice_sel_c;
                active_d  = active_q | voice_sel_c;
              end else begin
                set_bad = 1'b1;
              end
            end
            A_NOTE_OFF: begin
              if (voice_ok_c) begin
                note_off_d = voice_sel_c;
                active_d   = active_q & ~voice_sel_c;
              end else begin
                set_bad = 1'b1;
              end
            end
            A_ID, A_STATUS, A_ACTIVE: ;
            default: set_bad = 1'b1;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Read-to-clear; a simultaneous set takes priority
    if (clr_status) begin
      bad_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (set_bad) bad_d = 1'b1;
    if (set_tmo) tmo_d = 1'b1;
  end

  always_ff @(posedge clk96m) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      to_cnt_q   <= '0;
      div_q      <= RATE_DIV_RST;
      div_sh_q   <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      bad_q      <= 1'b0;
      tmo_q      <= 1'b0;
      led_q      <= '0;
      active_q   <= '0;
      note_on_q  <= '0;
      note_off_q <= '0;
      data_tx_q  <= '0;
      vtx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      to_cnt_q   <= to_cnt_d;
      div_q      <= div_d;
      div_sh_q   <= div_sh_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      bad_q      <= bad_d;
      tmo_q      <= tmo_d;
      led_q      <= led_d;
      active_q   <= active_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      data_tx_q  <= data_tx_d;
      vtx_q      <= vtx_d;
    end
  end

  assign data_tx       = data_tx_q;
  assign valid_data_tx = vtx_q;
  assign note_on       = note_on_q;
  assign note_off      = note_off_q;
  assign active        = active_q;
  assign sample_tick   = tick_q;
  assign led           = led_q;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl (4 voices, short write timeout).
module tb_uart_reg_ctrl;

  localparam int unsigned NV  = 4;
  localparam int unsigned TMO = 40;

  logic          clk96m = 1'b0;
  logic          rst    = 1'b1;
  logic [7:0]    data_rx = 8'h00;
  logic          valid_data_rx = 1'b0;
  logic [7:0]    data_tx;
  logic          valid_data_tx;
  logic [NV-1:0] note_on, note_off, active;
  logic          sample_tick;
  logic [3:0]    led;

  int n_chk = 0;
  int n_err = 0;
  int gap;

  uart_reg_ctrl #(
    .NUM_VOICES    (NV),
    .TIMEOUT_CYCLES(TMO),
    .RATE_DIV_RST  (16'd2000),
    .ID_VALUE      (8'h5A)
  ) dut (
    .clk96m       (clk96m),
    .rst          (rst),
    .data_rx      (data_rx),
    .valid_data_rx(valid_data_rx),
    .data_tx      (data_tx),
    .valid_data_tx(valid_data_tx),
    .note_on      (note_on),
    .note_off     (note_off),
    .active       (active),
    .sample_tick  (sample_tick),
    .led          (led)
  );

  always #5 clk96m = ~clk96m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was sampled
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk96m);
    data_rx       = b;
    valid_data_rx = 1'b1;
    @(negedge clk96m);
    valid_data_rx = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    send_byte({1'b0, a});
    check({tag, "_vld"}, 32'(valid_data_tx), 32'd1);
    check({tag, "_dat"}, 32'(data_tx), 32'(exp));
    @(negedge clk96m);
    check({tag, "_vld_off"}, 32'(valid_data_tx), 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    send_byte({1'b1, a});
    send_byte(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk96m);
  endtask

  // Cycles until the next sample_tick, bounded
  task automatic meas_gap(output int g);
    int c;
    c = 0;
    do begin
      @(negedge clk96m);
      c++;
    end while (sample_tick !== 1'b1 && c < 5000);
    g = c;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_vtx",    32'(valid_data_tx), 32'd0);
    check("rst_non",    32'(note_on),       32'd0);
    check("rst_noff",   32'(note_off),      32'd0);
    check("rst_active", 32'(active),        32'd0);
    check("rst_tick",   32'(sample_tick),   32'd0);
    check("rst_led",    32'(led),           32'd0);
    check("rst_dtx",    32'(data_tx),       32'd0);
    rst = 1'b0;

    // Reads after reset
    rd("id", 7'h00, 8'h5A);
    rd("act0", 7'h07, 8'h00);
    rd("div_lo_rst", 7'h02, 8'hD0);

    // Note on / off of voice 2
    wr(7'h05, 8'h02);
    check("non2", 32'(note_on), 32'h4);
    check("non2_act", 32'(active), 32'h4);
    @(negedge clk96m);
    check("non2_1cyc", 32'(note_on), 32'h0);
    wr(7'h06, 8'h02);
    check("noff2", 32'(note_off), 32'h4);
    check("noff2_act", 32'(active), 32'h0);
    @(negedge clk96m);
    check("noff2_1cyc", 32'(note_off), 32'h0);

    // Two voices, re-strobe on an active voice, bitmap read
    wr(7'h05, 8'h00);
    wr(7'h05, 8'h03);
    wr(7'h05, 8'h03);
    check("restrobe", 32'(note_on), 32'h8);
    rd("act9", 7'h07, 8'h09);

    // Out-of-range voice: no strobe, bad flag, read-to-clear
    wr(7'h05, 8'h09);
    check("badv_non", 32'(note_on), 32'h0);
    check("badv_act", 32'(active), 32'h9);
    rd("st_bad", 7'h01, 8'h02);
    rd("st_clr", 7'h01, 8'h00);

    // Unmapped address read
    rd("unmapped", 7'h20, 8'h00);
    rd("st_bad2", 7'h01, 8'h02);

    // Data byte in the last cycle before timeout is still accepted
    send_byte(8'h84);
    idle(TMO - 2);
    send_byte(8'h03);
    check("led_last", 32'(led), 32'h3);

    // Write timeout: LED unchanged, timeout flag set
    send_byte(8'h84);
    idle(TMO + 5);
    check("tmo_led", 32'(led), 32'h3);
    rd("tmo_led_rd", 7'h04, 8'h03);
    rd("st_tmo", 7'h01, 8'h01);
    rd("st_tmo_clr", 7'h01, 8'h00);
    wr(7'h04, 8'h0F);
    check("led_f", 32'(led), 32'hF);
    rd("led_rd", 7'h04, 8'h0F);

    // Reset divider period, DIV_LO alone does not change it
    meas_gap(gap);
    meas_gap(gap);
    check("period_rst", 32'(gap), 32'd2001);
    wr(7'h02, 8'h09);
    rd("div_lo_committed", 7'h02, 8'hD0);
    meas_gap(gap);
    meas_gap(gap);
    check("period_lo_only", 32'(gap), 32'd2001);

    // DIV_HI commit: period 10 counted from the commit
    wr(7'h03, 8'h00);
    check("commit_tick0", 32'(sample_tick), 32'd0);
    meas_gap(gap);
    check("first_gap10", 32'(gap), 32'd10);
    meas_gap(gap);
    check("period10", 32'(gap), 32'd10);
    rd("div_lo_new", 7'h02, 8'h09);

    // DIV = 0: tick every cycle
    wr(7'h02, 8'h00);
    wr(7'h03, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk96m);
      check("tick_every", 32'(sample_tick), 32'd1);
    end

    // Reset in the middle of a write
    send_byte(8'h83);
    @(negedge clk96m);
    rst = 1'b1;
    idle(2);
    check("mid_led",    32'(led),           32'h0);
    check("mid_active", 32'(active),        32'h0);
    check("mid_tick",   32'(sample_tick),   32'd0);
    check("mid_vtx",    32'(valid_data_tx), 32'd0);
    check("mid_non",    32'(note_on),       32'd0);
    rst = 1'b0;
    rd("mid_div_lo", 7'h02, 8'hD0);
    rd("mid_div_hi", 7'h03, 8'h07);
    rd("mid_st", 7'h01, 8'h00);
    meas_gap(gap);
    meas_gap(gap);
    check("mid_period", 32'(gap), 32'd2001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
